// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller.
// Size encodings, FSM states, RAM strobes and lane helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic       RAM_EN  = 1'b1;
  localparam logic       RAM_DIS = 1'b0;
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [31:0] ZERO_W = 32'h0;

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic m;
    m = 1'b1;
    unique case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = a[0];
      SZ_WORD: m = (a != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = BE_NONE;
    unique case (sz)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = BE_ALL;
      default: be = BE_NONE;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage to data memory request/response bundle.
// master drives requests, slave answers with ready/rvalid.
interface dmem_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       dataIn;
  logic              ready;
  logic              rvalid;
  logic [31:0]       dataOut;
  logic              misalign;

  modport master (
    output req, we, size, uns, addr, dataIn,
    input  ready, rvalid, dataOut, misalign
  );

  modport slave (
    input  req, we, size, uns, addr, dataIn,
    output ready, rvalid, dataOut, misalign
  );
endinterface

// File: rtl/dmem_ram.sv
// DEPTH x 32 RAM, byte write enables, registered read.
// Contents are deliberately not reset.
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // Lane write when any strobe is set, otherwise read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (|be) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: handshake FSM, lanes, extension.
// Optional DMEM_PERF_EN adds load/store/error counters.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic clk,
  input  logic rst,
  dmem_if.slave bus
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt,
  output logic [15:0] err_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_LD =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t        state, nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          acc, mis_in, ren, ram_en;
  logic [3:0]    be;
  logic [31:0]   wd, rdata, sh, ext;
  logic [AW-1:0] ram_a;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          we_q, uns_q, mis_q;
  logic          unused_ok;

  assign unused_ok = ^bus.addr[ADDR_W-1:AW+2];

  assign bus.ready = (state == IDLE) | (state == RESP);
  assign acc       = bus.req & bus.ready;
  assign mis_in    = misaligned(bus.size, bus.addr[1:0]);

  // State and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and RAM read strobe.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    ren     = RAM_DIS;
    unique case (state)
      IDLE, RESP: begin
        nxt = IDLE;
        if (acc) begin
          if (WAIT_STATES == 0) begin
            nxt = RESP;
            ren = RAM_EN;
          end else begin
            nxt     = WAIT;
            cnt_nxt = WS_LD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          nxt = RESP;
          ren = RAM_EN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Capture the accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      size_q <= SZ_BYTE;
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      mis_q  <= 1'b0;
    end else if (acc) begin
      addr_q <= bus.addr[AW+1:0];
      size_q <= bus.size;
      we_q   <= bus.we;
      uns_q  <= bus.uns;
      mis_q  <= mis_in;
    end
  end

  // Store data replicated across lanes.
  always_comb begin
    wd = bus.dataIn;
    unique case (1'b1)
      bus.size == SZ_BYTE: wd = {4{bus.dataIn[7:0]}};
      bus.size == SZ_HALF: wd = {2{bus.dataIn[15:0]}};
      default:             wd = bus.dataIn;
    endcase
  end

  assign be = (acc & bus.we & ~mis_in)
            ? lane_be(bus.size, bus.addr[1:0])
            : BE_NONE;

  assign ram_en = ren | (|be);
  assign ram_a  = acc ? bus.addr[AW+1:2] : addr_q[AW+1:2];

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .be    (be),
    .addr  (ram_a),
    .wdata (wd),
    .rdata (rdata)
  );

  assign sh = rdata >> {addr_q[1:0], 3'b000};

  // Load extension by captured size and sign mode.
  always_comb begin
    ext = ZERO_W;
    unique case (1'b1)
      size_q == SZ_BYTE:
        ext = uns_q ? {24'h0, sh[7:0]}
                    : {{24{sh[7]}}, sh[7:0]};
      size_q == SZ_HALF:
        ext = uns_q ? {16'h0, sh[15:0]}
                    : {{16{sh[15]}}, sh[15:0]};
      size_q == SZ_WORD:
        ext = sh;
      default:
        ext = ZERO_W;
    endcase
  end

  assign bus.rvalid   = (state == RESP);
  assign bus.misalign = (state == RESP) & mis_q;
  assign bus.dataOut  =
    (state == RESP && !we_q && !mis_q) ? ext : ZERO_W;

`ifdef DMEM_PERF_EN
  // Saturating access counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      err_cnt   <= '0;
    end else if (acc) begin
      if (mis_in) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
      end else if (bus.we) begin
        if (store_cnt != '1) store_cnt <= store_cnt + 32'd1;
      end else begin
        if (load_cnt != '1) load_cnt <= load_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: zero-wait and 3-wait instances.
// Expected responses are queued and popped on rvalid.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  typedef struct packed {
    bit          w;
    logic [1:0]  sz;
    bit          u;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
    bit          m;
  } op_t;

  typedef struct packed {
    logic [31:0] d;
    logic        m;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_v, we_v, un_v;
  logic [1:0]  sz_v [2];
  logic [31:0] ad_v [2];
  logic [31:0] di_v [2];
  logic [1:0]  rdy_v, rv_v, mis_v;
  logic [31:0] dout_v [2];

  exp_t exp_q [$];
  int total = 0;
  int bad = 0;
  bit got;
  int ol;
  logic [31:0] od;
  logic om;

  dmem_if #(.ADDR_W(32)) b0 ();
  dmem_if #(.ADDR_W(32)) b3 ();

  assign b0.req = req_v[0];
  assign b0.we = we_v[0];
  assign b0.size = sz_v[0];
  assign b0.uns = un_v[0];
  assign b0.addr = ad_v[0];
  assign b0.dataIn = di_v[0];
  assign b3.req = req_v[1];
  assign b3.we = we_v[1];
  assign b3.size = sz_v[1];
  assign b3.uns = un_v[1];
  assign b3.addr = ad_v[1];
  assign b3.dataIn = di_v[1];

  assign rdy_v = {b3.ready, b0.ready};
  assign rv_v = {b3.rvalid, b0.rvalid};
  assign mis_v = {b3.misalign, b0.misalign};
  assign dout_v[0] = b0.dataOut;
  assign dout_v[1] = b3.dataOut;

`ifdef DMEM_PERF_EN
  logic [31:0] lc0, sc0, lc1, sc1;
  logic [15:0] ec0, ec1;
`endif

  dmem_ctrl #(
    .DEPTH(1024), .WAIT_STATES(0), .ADDR_W(32)
  ) u0 (
    .clk(clk),
    .rst(rst),
    .bus(b0)
`ifdef DMEM_PERF_EN
    ,
    .load_cnt(lc0),
    .store_cnt(sc0),
    .err_cnt(ec0)
`endif
  );

  dmem_ctrl #(
    .DEPTH(1024), .WAIT_STATES(3), .ADDR_W(32)
  ) u3 (
    .clk(clk),
    .rst(rst),
    .bus(b3)
`ifdef DMEM_PERF_EN
    ,
    .load_cnt(lc1),
    .store_cnt(sc1),
    .err_cnt(ec1)
`endif
  );

  task automatic issue(input int ch, input op_t o);
    int n;
    int lat;
    lat = (ch == 0) ? 1 : 4;
    exp_q.push_back(exp_t'{o.e, o.m, lat});
    we_v[ch] = o.w;
    sz_v[ch] = o.sz;
    un_v[ch] = o.u;
    ad_v[ch] = o.a;
    di_v[ch] = o.d;
    req_v[ch] = 1'b1;
    n = 0;
    while (!rdy_v[ch] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_v[ch] = 1'b0;
    got = 1'b0;
    ol = 0;
    od = 'x;
    om = 1'bx;
    while (!got && ol < 40) begin
      @(negedge clk);
      ol++;
      if (rv_v[ch]) begin
        got = 1'b1;
        od = dout_v[ch];
        om = mis_v[ch];
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      total++;
      if (rdy_v[c] !== 1'b1 || rv_v[c] !== 1'b0 ||
          dout_v[c] !== 32'h0 || mis_v[c] !== 1'b0) begin
        bad++;
        $display("FAIL reset ch%0d: rdy=%b rv=%b d=%h m=%b want 1 0 0 0",
                 c, rdy_v[c], rv_v[c], dout_v[c], mis_v[c]);
      end
    end
`ifdef DMEM_PERF_EN
    total++;
    if (lc0 !== 0 || sc0 !== 0 || ec0 !== 0) begin
      bad++;
      $display("FAIL reset_perf: l=%0d s=%0d e=%0d want 0 0 0",
               lc0, sc0, ec0);
    end
`endif
  endtask

  task automatic run_check(input int ch, input op_t o,
                           input string nm, input int i);
    exp_t e;
    issue(ch, o);
    e = exp_q.pop_front();
    total++;
    if (!got || od !== e.d || om !== e.m || ol != e.lat) begin
      bad++;
      $display("FAIL %s op%0d: got v=%b d=%h m=%b lat=%0d want d=%h m=%b lat=%0d",
               nm, i, got, od, om, ol, e.d, e.m, e.lat);
    end
  endtask

  task automatic test_basic();
    op_t ops [2];
    ops = '{
      '{1'b1, SZ_WORD, 1'b0, 32'h10, 32'h800000FF, 32'h0, 1'b0},
      '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h800000FF, 1'b0}
    };
    foreach (ops[i]) run_check(0, ops[i], "basic", i);
  endtask

  task automatic test_subword();
    op_t ops [8];
    ops = '{
      '{1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0},
      '{1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0},
      '{1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 32'h000000FF, 1'b0},
      '{1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'hFFFF8000, 1'b0},
      '{1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'h00008000, 1'b0},
      '{1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 32'hFFFFFFFF, 1'b0},
      '{1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h123456AB, 32'h0, 1'b0},
      '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8000ABFF, 1'b0}
    };
    foreach (ops[i]) run_check(0, ops[i], "subword", i);
  endtask

  task automatic test_misalign();
    op_t ops [4];
    op_t ill;
    ops = '{
      '{1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0},
      '{1'b0, SZ_HALF, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1},
      '{1'b1, SZ_WORD, 1'b0, 32'h22, 32'hDEADBEEF, 32'h0, 1'b1},
      '{1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0}
    };
    foreach (ops[i]) run_check(0, ops[i], "misalign", i);
`ifdef DMEM_PERF_EN
    total++;
    if (ec0 !== 16'd2) begin
      bad++;
      $display("FAIL err_cnt: got %0d want 2", ec0);
    end
`endif
    ill = '{1'b0, SZ_ILL, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1};
    run_check(0, ill, "illegal", 0);
  endtask

  task automatic test_wrap();
    op_t ops [3];
    ops = '{
      '{1'b1, SZ_WORD, 1'b0, 32'h1000, 32'h12345678, 32'h0, 1'b0},
      '{1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0},
      '{1'b0, SZ_WORD, 1'b0, 32'h2000, 32'h0, 32'h12345678, 1'b0}
    };
    foreach (ops[i]) run_check(0, ops[i], "wrap", i);
  endtask

  task automatic test_wait();
    op_t ops [2];
    ops = '{
      '{1'b1, SZ_WORD, 1'b0, 32'h50, 32'h55AA33CC, 32'h0, 1'b0},
      '{1'b0, SZ_BYTE, 1'b0, 32'h50, 32'h0, 32'hFFFFFFCC, 1'b0}
    };
    foreach (ops[i]) run_check(1, ops[i], "wait3", i);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic er;
    we_v[1] = 1'b0;
    sz_v[1] = SZ_WORD;
    un_v[1] = 1'b0;
    ad_v[1] = 32'h50;
    req_v[1] = 1'b1;
    exp_q.push_back(exp_t'{32'h55AA33CC, 1'b0, 4});
    exp_q.push_back(exp_t'{32'h000055AA, 1'b0, 8});
    @(posedge clk);
    #1;
    sz_v[1] = SZ_HALF;
    un_v[1] = 1'b1;
    ad_v[1] = 32'h52;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      er = !((c >= 1 && c <= 3) || (c >= 5 && c <= 7));
      total++;
      if (rdy_v[1] !== er) begin
        bad++;
        $display("FAIL b2b_ready c%0d: got %b want %b",
                 c, rdy_v[1], er);
      end
      if (rv_v[1]) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra c%0d: got rvalid want none", c);
        end else begin
          e = exp_q.pop_front();
          if (dout_v[1] !== e.d || mis_v[1] !== e.m ||
              c != e.lat) begin
            bad++;
            $display("FAIL b2b_resp: got d=%h m=%b c=%0d want d=%h m=%b c=%0d",
                     dout_v[1], mis_v[1], c, e.d, e.m, e.lat);
          end
        end
      end
      if (rv_v[1] && req_v[1]) begin
        @(posedge clk);
        #1 req_v[1] = 1'b0;
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_missing: got %0d pending want 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    op_t st, ld;
    bit seen;
    st = '{1'b1, SZ_WORD, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0};
    ld = '{1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0};
    run_check(1, st, "rst_store", 0);
    we_v[1] = 1'b0;
    sz_v[1] = SZ_WORD;
    ad_v[1] = 32'h40;
    req_v[1] = 1'b1;
    @(posedge clk);
    #1 req_v[1] = 1'b0;
    @(negedge clk);
    total++;
    if (rdy_v[1] !== 1'b0) begin
      bad++;
      $display("FAIL rst_inwait: got ready=%b want 0", rdy_v[1]);
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if (rdy_v[1] !== 1'b1 || dout_v[1] !== 32'h0 ||
        rv_v[1] !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got rdy=%b d=%h rv=%b want 1 0 0",
               rdy_v[1], dout_v[1], rv_v[1]);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rv_v[1]) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_drop: got rvalid=%b want 0", seen);
    end
    rst = 1'b1;
    @(negedge clk);
    run_check(1, ld, "rst_keep", 0);
  endtask

  initial begin
    rst = 1'b0;
    req_v = '0;
    we_v = '0;
    un_v = '0;
    for (int c = 0; c < 2; c++) begin
      sz_v[c] = SZ_WORD;
      ad_v[c] = '0;
      di_v[c] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_basic();
    test_subword();
    test_misalign();
    test_wrap();
    test_wait();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Next-generation data memory for the single-cycle/multi-cycle CPU, serving all MIPS load/store widths: LB, LBU, LH, LHU, LW, SB, SH, SW.
- Depth and access latency are parametrised, with a req/ready/rvalid handshake.
- Little-endian byte lanes, sign/zero extension and misalignment detection are done inside the block.
- Sits between the MEM stage and the on-chip RAM array.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, min 4.
- WAIT_STATES, 0, extra cycles between accept and response; range 0..15.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  1  request valid
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- uns  in  1  load zero-extend (LBU/LHU); ignored for stores and words
- addr  in  ADDR_W  byte address
- dataIn  in  32  store data, right-aligned
- ready  out  1  block can accept a request this cycle
- rvalid  out  1  one-cycle response pulse (loads and stores)
- dataOut  out  32  extended load data; valid while rvalid=1
- misalign  out  1  error flag qualified by rvalid

Behaviour:
- States are IDLE, WAIT, RESP. Accept = req & ready on a rising edge.
- ready = (state==IDLE) | (state==RESP), so back-to-back requests are accepted in the RESP cycle.
- Accept edge:
  - Capture we/size/uns/addr/dataIn.
  - Misaligned when size=01 & addr[0], or size=10 & addr[1:0]!=0, or size=11.
  - A store writes the RAM at this same edge.
  - A misaligned or illegal store writes nothing.
- Next state: WAIT_STATES==0 -> RESP; otherwise WAIT with the counter loaded to WAIT_STATES-1.
- WAIT: the counter decrements each cycle; at 0 go to RESP. The response therefore comes WAIT_STATES+1 cycles after the accept edge.
- RESP:
  - rvalid=1 and misalign is driven.
  - For a load, dataOut is the registered read taken at the RESP-entering edge.
  - Next state is WAIT/RESP on a new accept, otherwise IDLE.
- Word index = addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Stores:
  - SB writes lane addr[1:0] with dataIn[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with dataIn[15:0].
  - SW writes all lanes. Other lanes are unchanged.
- Loads:
  - Selected lane(s) are shifted to bit 0.
  - Bytes/halves are sign-extended when uns=0, zero-extended when uns=1.
  - A misaligned load returns dataOut=0.
- A load accepted in the cycle after a store response returns the new data; there is no stale read.
- Store responses: dataOut=0.
- Reset (async assert):
  - state=IDLE, ready=1, rvalid=0, dataOut=0, misalign=0, counter=0.
  - An in-flight response is dropped.
  - RAM contents are not reset; a store accepted before reset stays written.
- req while ready=0 is ignored; the requester holds its request.

Optional Feature:
- Macro DMEM_PERF_EN.
- Defined:
  - Adds outputs load_cnt[31:0], store_cnt[31:0] and err_cnt[15:0], all reset to 0.
  - load_cnt and store_cnt increment on each accepted aligned load or store.
  - err_cnt increments on each accepted misaligned or illegal request.
  - All three counters saturate at max.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - state enum IDLE/WAIT/RESP;
  - RamEnable/RamWrite-style constants and the zero word.
- Sub-module dmem_ram: DEPTH x 32 array with a 4-bit byte-write-enable, synchronous write and synchronous registered read.
- The FSM, lane steering and extension logic stay in dmem_ctrl.

Test Plan:
1. WAIT_STATES=0: SW 0x8000_00FF to 0x10, then LW 0x10 -> rvalid exactly 1 cycle after accept, dataOut=0x8000_00FF, misalign=0.
2. Sub-word loads from 0x10: LB 0x13 -> 0xFFFF_FF80; LBU 0x13 -> 0x0000_0080; LH 0x10 -> 0x0000_00FF; SB 0xAB to 0x11 then LW 0x10 -> 0x8000_ABFF.
3. Misalignment: LH 0x21 and SW 0x22 -> rvalid with misalign=1; LW 0x20 then shows the word at 0x20 unchanged. With DMEM_PERF_EN, err_cnt=2.
4. WAIT_STATES=3: accept at cycle t -> ready low t+1..t+3, rvalid at t+4. A back-to-back req held high is accepted in the RESP cycle.
5. DEPTH=1024 wrap: SW 0x1234_5678 to 0x1000, then LW 0x0 -> 0x1234_5678.
6. rst low while in WAIT -> rvalid never pulses, ready=1 and dataOut=0 immediately. A store accepted before reset is still readable after release.
